// File: rtl/buffer_seq_ctrl_pkg.sv
// Shared types and constants for the AFE data-buffer sequencer.
// The state decode function maps each state to its registered output pattern.
package buffer_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_DIAG   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_STREAM = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam logic [1:0] DATA_CTRL_IDLE   = 2'b00;
    localparam logic [1:0] DATA_CTRL_DIAG   = 2'b01;
    localparam logic [1:0] DATA_CTRL_STREAM = 2'b10;

    localparam logic [1:0] DIAG_OK  = 2'b10;
    localparam logic [1:0] DIAG_ERR = 2'b01;

    localparam int WD_W = 16;

    typedef struct packed {
        logic [1:0] ctrl;
        logic       buf_reset_n;
        logic       busy;
        logic       fault;
    } state_out_t;

    function automatic state_out_t state_outputs(input state_e st);
        state_out_t o;
        o.ctrl        = DATA_CTRL_IDLE;
        o.buf_reset_n = 1'b1;
        o.busy        = 1'b1;
        o.fault       = 1'b0;
        case (st)
            ST_IDLE:   o.busy = 1'b0;
            ST_CLEAR:  o.buf_reset_n = 1'b0;
            ST_DIAG:   o.ctrl = DATA_CTRL_DIAG;
            ST_SETTLE: o.ctrl = DATA_CTRL_IDLE;
            ST_STREAM: o.ctrl = DATA_CTRL_STREAM;
            ST_FAULT: begin
                o.busy  = 1'b0;
                o.fault = 1'b1;
            end
            default:   o.busy = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/buffer_seq_ctrl_watchdog.sv
// Cycle watchdog shared by DIAG, SETTLE and STREAM. A cycle with i_clear counts as
// cycle zero of a new interval; o_expired fires on the cycle whose index is i_limit-1.
module buffer_seq_ctrl_watchdog
    import buffer_seq_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_enable,
    input  logic [WD_W-1:0] i_limit,
    output logic            o_expired
);

    logic [WD_W-1:0] r_cnt;
    logic [WD_W-1:0] w_cur;

    assign w_cur     = i_clear ? {WD_W{1'b0}} : r_cnt;
    assign o_expired = i_enable && (w_cur == (i_limit - {{(WD_W-1){1'b0}}, 1'b1}));

    // Interval counter; idles at zero while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {WD_W{1'b0}};
        end else if (i_enable) begin
            r_cnt <= w_cur + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= {WD_W{1'b0}};
        end
    end

endmodule

// File: rtl/buffer_seq_ctrl.sv
// AFE data-buffer sequencer: buffer clear, diagnostic with retry, settle, then streaming
// with sample-strobe to FIFO-write conversion, frame counting and watchdog supervision.
module buffer_seq_ctrl
    import buffer_seq_ctrl_pkg::*;
#(
    parameter int DIAG_TIMEOUT   = 1024,
    parameter int STRM_TIMEOUT   = 65535,
    parameter int SETTLE_CYCLES  = 16,
    parameter int MAX_DIAG_RETRY = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             in_reset,
    input  logic             in_start,
    input  logic             in_stop,
    input  logic             in_clear_fault,
    input  logic [1:0]       in_diag_er,
    input  logic             in_new_samples,
    input  logic             in_strm_dn,
    input  logic             in_fifo_full,
    output logic [1:0]       out_data_control,
    output logic             out_buf_reset_n,
    output logic             out_fifo_wr,
    output logic [CNT_W-1:0] out_sample_cnt,
    output logic [2:0]       out_state,
    output logic             out_busy,
    output logic             out_fault,
    output logic             out_diag_fail,
    output logic             out_timeout,
    output logic             out_overrun
);

    localparam logic [WD_W-1:0] DIAG_LIM   = WD_W'(DIAG_TIMEOUT);
    localparam logic [WD_W-1:0] SETTLE_LIM = WD_W'(SETTLE_CYCLES);
    localparam logic [WD_W-1:0] STRM_LIM   = WD_W'(STRM_TIMEOUT);
    localparam logic [3:0]      RETRY_MAX  = 4'(MAX_DIAG_RETRY);

    state_e           r_state;
    state_out_t       r_out;
    logic             r_fifo_wr;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [3:0]       r_retry;
    logic             r_clr_cnt;
    logic             r_wd_clr;
    logic             r_ns_prev;
    logic             r_diag_fail;
    logic             r_timeout;
    logic             r_overrun;

    logic             w_wd_en;
    logic             w_wd_clr;
    logic             w_wd_expired;
    logic [WD_W-1:0]  w_wd_limit;
    logic             w_ns_edge;

    assign w_wd_en   = (r_state == ST_DIAG) || (r_state == ST_SETTLE) || (r_state == ST_STREAM);
    assign w_wd_clr  = r_wd_clr || ((r_state == ST_STREAM) && in_strm_dn);
    assign w_ns_edge = in_new_samples && !r_ns_prev;

    // Per-state watchdog limit
    always_comb begin
        w_wd_limit = STRM_LIM;
        case (r_state)
            ST_DIAG:   w_wd_limit = DIAG_LIM;
            ST_SETTLE: w_wd_limit = SETTLE_LIM;
            default:   w_wd_limit = STRM_LIM;
        endcase
    end

    buffer_seq_ctrl_watchdog u_watchdog (
        .clk       (clk),
        .rst       (in_reset),
        .i_clear   (w_wd_clr),
        .i_enable  (w_wd_en),
        .i_limit   (w_wd_limit),
        .o_expired (w_wd_expired)
    );

    // Sequencer FSM with registered outputs, frame counter and sticky status
    always_ff @(posedge clk or posedge in_reset) begin
        if (in_reset) begin
            r_state      <= ST_IDLE;
            r_out        <= state_outputs(ST_IDLE);
            r_fifo_wr    <= 1'b0;
            r_sample_cnt <= {CNT_W{1'b0}};
            r_retry      <= 4'd0;
            r_clr_cnt    <= 1'b0;
            r_wd_clr     <= 1'b0;
            r_ns_prev    <= 1'b0;
            r_diag_fail  <= 1'b0;
            r_timeout    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_ns_prev <= in_new_samples;
            r_fifo_wr <= 1'b0;
            r_wd_clr  <= 1'b0;
            // Stop aborts every active state, ahead of verdicts, expiries and sample edges
            if (in_stop && r_out.busy) begin
                r_state   <= ST_IDLE;
                r_out     <= state_outputs(ST_IDLE);
                r_clr_cnt <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (in_start) begin
                            r_state      <= ST_CLEAR;
                            r_out        <= state_outputs(ST_CLEAR);
                            r_clr_cnt    <= 1'b0;
                            r_sample_cnt <= {CNT_W{1'b0}};
                            r_retry      <= 4'd0;
                            r_diag_fail  <= 1'b0;
                            r_timeout    <= 1'b0;
                            r_overrun    <= 1'b0;
                        end
                    end
                    ST_CLEAR: begin
                        if (r_clr_cnt) begin
                            r_state   <= ST_DIAG;
                            r_out     <= state_outputs(ST_DIAG);
                            r_clr_cnt <= 1'b0;
                            r_wd_clr  <= 1'b1;
                        end else begin
                            r_clr_cnt <= 1'b1;
                        end
                    end
                    ST_DIAG: begin
                        if (in_diag_er == DIAG_OK) begin
                            r_state  <= ST_SETTLE;
                            r_out    <= state_outputs(ST_SETTLE);
                            r_wd_clr <= 1'b1;
                        end else if ((in_diag_er & DIAG_ERR) != 2'b00) begin
                            if (r_retry < RETRY_MAX) begin
                                r_retry   <= r_retry + 4'd1;
                                r_state   <= ST_CLEAR;
                                r_out     <= state_outputs(ST_CLEAR);
                                r_clr_cnt <= 1'b0;
                            end else begin
                                r_diag_fail <= 1'b1;
                                r_state     <= ST_FAULT;
                                r_out       <= state_outputs(ST_FAULT);
                            end
                        end else if (w_wd_expired) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_FAULT;
                            r_out     <= state_outputs(ST_FAULT);
                        end
                    end
                    ST_SETTLE: begin
                        if (w_wd_expired) begin
                            r_state  <= ST_STREAM;
                            r_out    <= state_outputs(ST_STREAM);
                            r_wd_clr <= 1'b1;
                        end
                    end
                    ST_STREAM: begin
                        // A watchdog expiry abandons any sample edge in the same cycle
                        if (w_wd_expired) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_FAULT;
                            r_out     <= state_outputs(ST_FAULT);
                        end else if (w_ns_edge) begin
                            if (in_fifo_full) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_fifo_wr <= 1'b1;
                                if (r_sample_cnt != {CNT_W{1'b1}}) begin
                                    r_sample_cnt <= r_sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                                end
                            end
                        end
                    end
                    ST_FAULT: begin
                        if (in_clear_fault) begin
                            r_state <= ST_IDLE;
                            r_out   <= state_outputs(ST_IDLE);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_out   <= state_outputs(ST_IDLE);
                    end
                endcase
            end
        end
    end

    assign out_data_control = r_out.ctrl;
    assign out_buf_reset_n  = r_out.buf_reset_n;
    assign out_busy         = r_out.busy;
    assign out_fault        = r_out.fault;
    assign out_state        = r_state;
    assign out_fifo_wr      = r_fifo_wr;
    assign out_sample_cnt   = r_sample_cnt;
    assign out_diag_fail    = r_diag_fail;
    assign out_timeout      = r_timeout;
    assign out_overrun      = r_overrun;

endmodule

// File: tb/tb_buffer_seq_ctrl.sv
// Self-checking bench for buffer_seq_ctrl: vector table, directed corner sequences and
// randomized stimulus, all compared every cycle against a behavioural model.
module tb_buffer_seq_ctrl;

    localparam int DIAG_TO = 1024;
    localparam int STRM_TO = 40;
    localparam int SETTLE  = 16;
    localparam int MAXR    = 2;
    localparam int CW      = 4;
    localparam logic [15:0] RST_VEC = {3'd0, 2'b00, 1'b1, 1'b0, 4'd0, 5'd0};

    logic clk = 1'b0;
    logic rst;
    logic i_start, i_stop, i_clr, i_ns, i_dn, i_full;
    logic [1:0] i_diag;
    logic [1:0] o_ctrl;
    logic o_rstn, o_wr, o_busy, o_fault, o_df, o_to, o_ov;
    logic [CW-1:0] o_cnt;
    logic [2:0] o_state;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: phase, cycles elapsed in the phase, retries, counters and flags
    int m_st, m_el, m_retry;
    logic [CW-1:0] m_cnt;
    bit m_wr, m_prev, m_df, m_to, m_ov;

    always #5 clk = ~clk;

    buffer_seq_ctrl #(
        .DIAG_TIMEOUT(DIAG_TO), .STRM_TIMEOUT(STRM_TO), .SETTLE_CYCLES(SETTLE),
        .MAX_DIAG_RETRY(MAXR), .CNT_W(CW)
    ) dut (
        .clk(clk), .in_reset(rst), .in_start(i_start), .in_stop(i_stop),
        .in_clear_fault(i_clr), .in_diag_er(i_diag), .in_new_samples(i_ns),
        .in_strm_dn(i_dn), .in_fifo_full(i_full), .out_data_control(o_ctrl),
        .out_buf_reset_n(o_rstn), .out_fifo_wr(o_wr), .out_sample_cnt(o_cnt),
        .out_state(o_state), .out_busy(o_busy), .out_fault(o_fault),
        .out_diag_fail(o_df), .out_timeout(o_to), .out_overrun(o_ov)
    );

    function automatic void model_reset();
        m_st = 0; m_el = 0; m_retry = 0; m_cnt = '0;
        m_wr = 0; m_prev = 0; m_df = 0; m_to = 0; m_ov = 0;
    endfunction

    function automatic void model_step();
        bit edge_s;
        edge_s = i_ns && !m_prev;
        m_prev = i_ns;
        m_wr = 0;
        if (i_stop && m_st >= 1 && m_st <= 4) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (i_start) begin
                    m_st = 1; m_el = 0; m_cnt = '0; m_retry = 0; m_df = 0; m_to = 0; m_ov = 0;
                end
                1: if (m_el == 1) begin m_st = 2; m_el = 0; end else m_el++;
                2: begin
                    if (i_diag == 2'b10) begin
                        m_st = 3; m_el = 0;
                    end else if (i_diag == 2'b01 || i_diag == 2'b11) begin
                        if (m_retry < MAXR) begin m_retry++; m_st = 1; m_el = 0; end
                        else begin m_df = 1; m_st = 5; end
                    end else if (m_el == DIAG_TO - 1) begin
                        m_to = 1; m_st = 5;
                    end else m_el++;
                end
                3: if (m_el == SETTLE - 1) begin m_st = 4; m_el = 0; end else m_el++;
                4: begin
                    if (!i_dn && m_el == STRM_TO - 1) begin
                        m_to = 1; m_st = 5;
                    end else begin
                        m_el = i_dn ? 1 : m_el + 1;
                        if (edge_s) begin
                            if (i_full) m_ov = 1;
                            else begin
                                m_wr = 1;
                                if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
                            end
                        end
                    end
                end
                5: if (i_clr) m_st = 0;
                default: m_st = 0;
            endcase
        end
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [1:0] c;
        c = (m_st == 2) ? 2'b01 : (m_st == 4) ? 2'b10 : 2'b00;
        return {3'(m_st), c, (m_st != 1), m_wr, m_cnt,
                (m_st >= 1 && m_st <= 4), (m_st == 5), m_df, m_to, m_ov};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {o_state, o_ctrl, o_rstn, o_wr, o_cnt, o_busy, o_fault, o_df, o_to, o_ov};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    task automatic go_stream();
        bit ok = 0;
        i_start = 1; i_diag = 2'b10; i_dn = 1; i_stop = 0; i_ns = 0; i_full = 0;
        tick();
        i_start = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            tick();
            ok = (o_state == 3'd4);
        end
        chk("reach_stream", 32'(ok), 32'd1);
        i_diag = 2'b00;
    endtask

    typedef struct {
        bit start; bit [1:0] diag; bit ns; int reps;
        logic [2:0] st; logic [1:0] ctrl; logic rstn; logic wr; logic [CW-1:0] cnt;
    } vec_t;
    vec_t tbl[14];

    initial begin
        int entries, ndiag, nstrm, prev, r;
        bit done;

        tbl[0]  = '{1'b1, 2'b00, 1'b0, 1,  3'd1, 2'b00, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 2'b00, 1'b0, 1,  3'd1, 2'b00, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 2'b00, 1'b0, 1,  3'd2, 2'b01, 1'b1, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 2'b00, 1'b0, 4,  3'd2, 2'b01, 1'b1, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 2'b10, 1'b0, 1,  3'd3, 2'b00, 1'b1, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 2'b00, 1'b0, 15, 3'd3, 2'b00, 1'b1, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 2'b00, 1'b0, 1,  3'd4, 2'b10, 1'b1, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 2'b00, 1'b1, 1,  3'd4, 2'b10, 1'b1, 1'b1, 4'd1};
        tbl[8]  = '{1'b0, 2'b00, 1'b0, 1,  3'd4, 2'b10, 1'b1, 1'b0, 4'd1};
        tbl[9]  = '{1'b0, 2'b00, 1'b1, 1,  3'd4, 2'b10, 1'b1, 1'b1, 4'd2};
        tbl[10] = '{1'b0, 2'b00, 1'b1, 1,  3'd4, 2'b10, 1'b1, 1'b0, 4'd2};
        tbl[11] = '{1'b0, 2'b00, 1'b0, 1,  3'd4, 2'b10, 1'b1, 1'b0, 4'd2};
        tbl[12] = '{1'b0, 2'b00, 1'b1, 1,  3'd4, 2'b10, 1'b1, 1'b1, 4'd3};
        tbl[13] = '{1'b0, 2'b00, 1'b0, 1,  3'd4, 2'b10, 1'b1, 1'b0, 4'd3};

        rst = 1; i_start = 0; i_stop = 0; i_clr = 0; i_diag = 2'b00;
        i_ns = 0; i_dn = 1; i_full = 0;
        model_reset();
        #12;
        chk("reset_values", 32'(dut_vec()), 32'(RST_VEC));
        rst = 0;

        // Start-up sequence and three sample strobes
        for (int i = 0; i < 14; i++) begin
            i_start = tbl[i].start; i_diag = tbl[i].diag; i_ns = tbl[i].ns;
            for (int k = 0; k < tbl[i].reps; k++) begin
                tick();
                chk($sformatf("vec%0d", i), 32'({o_state, o_ctrl, o_rstn, o_wr, o_cnt}),
                    32'({tbl[i].st, tbl[i].ctrl, tbl[i].rstn, tbl[i].wr, tbl[i].cnt}));
            end
        end

        // FIFO full at an edge, then stop together with an edge
        i_full = 1; i_ns = 1; tick();
        chk("full_edge", 32'({o_wr, o_ov, o_cnt}), 32'({1'b0, 1'b1, 4'd3}));
        i_full = 0; i_ns = 0; tick();
        i_ns = 1; i_stop = 1; tick();
        chk("stop_edge", 32'({o_state, o_ctrl, o_wr}), 32'({3'd0, 2'b00, 1'b0}));
        i_stop = 0; i_ns = 0; tick();
        chk("stop_no_late_wr", 32'({o_wr, o_cnt}), 32'({1'b0, 4'd3}));

        // Diagnostic errors exhaust the retries
        i_start = 1; i_diag = 2'b01; entries = 0; prev = 0; done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            tick();
            i_start = 0;
            if (o_state == 3'd1 && prev != 1) entries++;
            prev = o_state;
            done = (o_state == 3'd5);
        end
        chk("diag_fault_reached", 32'(done), 32'd1);
        chk("diag_clear_entries", 32'(entries), 32'd3);
        chk("diag_fail_flags", 32'({o_df, o_to, o_fault, o_ctrl}), 32'({1'b1, 1'b0, 1'b1, 2'b00}));
        i_diag = 2'b00; i_start = 1; i_stop = 1;
        repeat (3) tick();
        chk("fault_ignores_start_stop", 32'(o_state), 32'd5);
        i_start = 0; i_stop = 0; i_clr = 1; tick(); i_clr = 0;
        chk("clear_fault_keeps_flag", 32'({o_state, o_df}), 32'({3'd0, 1'b1}));

        // Diagnostic timeout with verdict held pending
        i_start = 1; tick(); i_start = 0;
        ndiag = 0; done = 0;
        for (int k = 0; k < 1100 && !done; k++) begin
            tick();
            if (o_state == 3'd2) ndiag++;
            done = (o_state == 3'd5);
        end
        chk("diag_timeout_reached", 32'(done), 32'd1);
        chk("diag_timeout_cycles", 32'(ndiag), 32'(DIAG_TO));
        chk("diag_timeout_flags", 32'({o_to, o_df}), 32'({1'b1, 1'b0}));
        i_clr = 1; tick(); i_clr = 0;
        chk("timeout_clear_idle", 32'({o_state, o_to}), 32'({3'd0, 1'b1}));

        // Stream watchdog expiry without data-ready
        go_stream();
        i_dn = 0; nstrm = 1; done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            tick();
            if (o_state == 3'd4) nstrm++;
            done = (o_state == 3'd5);
        end
        chk("strm_timeout_cycles", 32'(nstrm), 32'(STRM_TO));
        chk("strm_timeout_flag", 32'({o_state, o_to}), 32'({3'd5, 1'b1}));
        i_clr = 1; tick(); i_clr = 0;

        // Data-ready on the expiry cycle keeps streaming
        go_stream();
        i_dn = 0;
        repeat (STRM_TO - 1) tick();
        i_dn = 1; tick();
        chk("strm_dn_wins", 32'({o_state, o_to}), 32'({3'd4, 1'b0}));
        i_stop = 1; tick(); i_stop = 0;

        // Frame counter saturation
        go_stream();
        repeat (17) begin
            i_ns = 1; tick();
            i_ns = 0; tick();
        end
        chk("cnt_saturates", 32'(o_cnt), 32'hF);

        // Asynchronous reset mid-stream
        #3 rst = 1;
        #1 chk("async_reset", 32'(dut_vec()), 32'(RST_VEC));
        model_reset();
        @(posedge clk); #1;
        chk("reset_held", 32'(dut_vec()), 32'(RST_VEC));
        rst = 0;

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            i_start = ($urandom_range(0, 9) < 3);
            i_stop  = ($urandom_range(0, 99) < 2);
            i_clr   = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            i_diag  = (r < 5) ? 2'b00 : (r < 8) ? 2'b10 : (r == 8) ? 2'b01 : 2'b11;
            i_ns    = ($urandom_range(0, 2) == 0);
            i_dn    = ($urandom_range(0, 15) != 0);
            i_full  = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
